// File: rtl/tx_pkg.sv
// Shared types and helpers for the transmitter scheduler: state encoding,
// default word width, frame length derivation and a ceil-log2 helper.
package tx_pkg;

  typedef enum logic [1:0] {StIdle, StStart, StWait, StGap} state_e;

  localparam int unsigned DefBitLen = 7;

  // Start + parity + stop framing plus one turnaround cycle around the data bits.
  function automatic int unsigned frame_cycles(input int unsigned bit_len);
    return bit_len + 4;
  endfunction

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned p = 1; p < v; p = p << 1) r++;
    return r;
  endfunction

endpackage

// File: rtl/tx_scheduler_if.sv
// Client-side bundle of the scheduler: requests and words in, acks, frame
// completion and the serializer drive out.
interface tx_scheduler_if import tx_pkg::*; #(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned BIT_LEN = DefBitLen
);
  localparam int unsigned IdxW = clog2(N_REQ);

  logic [N_REQ-1:0]         req;
  logic [N_REQ*BIT_LEN-1:0] data_in;
  logic [N_REQ-1:0]         ack;
  logic [N_REQ-1:0]         done;
  logic                     tx_start;
  logic [BIT_LEN-1:0]       tx_data;
  logic                     busy;
  logic [IdxW-1:0]          grant_id;

  modport master (
    output req, data_in,
    input  ack, done, tx_start, tx_data, busy, grant_id
  );

  modport slave (
    input  req, data_in,
    output ack, done, tx_start, tx_data, busy, grant_id
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr_i,
// wrapping modulo N_REQ.
module rr_arbiter import tx_pkg::*; #(
  parameter int unsigned N_REQ = 4,
  localparam int unsigned IdxW = clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IdxW-1:0]  ptr_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic [IdxW-1:0]  idx_o,
  output logic             valid_o
);

  logic [IdxW-1:0] cand;

  always_comb begin
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    cand    = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      cand = IdxW'((32'(ptr_i) + i) % N_REQ);
      if (!valid_o && req_i[cand]) begin
        valid_o = 1'b1;
        idx_o   = cand;
      end
    end
    if (valid_o) gnt_o[idx_o] = 1'b1;
  end

endmodule

// File: rtl/tx_scheduler.sv
// Shares one serial transmitter among N_REQ clients: round-robin grant, word
// latch, one-cycle start pulse, frame timing and an enforced inter-frame gap.
module tx_scheduler import tx_pkg::*; #(
  parameter int unsigned N_REQ        = 4,
  parameter int unsigned BIT_LEN      = DefBitLen,
  parameter int unsigned FRAME_CYCLES = frame_cycles(BIT_LEN),
  parameter int unsigned GAP_CYCLES   = 1
) (
  input  logic           clk,
  input  logic           rstn,
  tx_scheduler_if.slave  bus
);

  localparam int unsigned IdxW   = clog2(N_REQ);
  localparam int unsigned CntMax = (FRAME_CYCLES > GAP_CYCLES) ? FRAME_CYCLES : GAP_CYCLES;
  localparam int unsigned CntW   = clog2(CntMax + 1);
  localparam logic [CntW-1:0] FrameLast = CntW'(FRAME_CYCLES - 1);
  localparam logic [CntW-1:0] GapLast   = CntW'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);

  state_e             state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [IdxW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [N_REQ-1:0]   ack_q, ack_d;
  logic [N_REQ-1:0]   done_q, done_d;
  logic               tx_start_q, tx_start_d;
  logic [BIT_LEN-1:0] tx_data_q, tx_data_d;
  logic               busy_q, busy_d;
  logic [IdxW-1:0]    grant_id_q, grant_id_d;

  logic [N_REQ-1:0]   arb_gnt;
  logic [IdxW-1:0]    arb_idx;
  logic               arb_valid;

  rr_arbiter #(
    .N_REQ (N_REQ)
  ) u_arb (
    .req_i   (bus.req),
    .ptr_i   (rr_ptr_q),
    .gnt_o   (arb_gnt),
    .idx_o   (arb_idx),
    .valid_o (arb_valid)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rr_ptr_d   = rr_ptr_q;
    ack_d      = '0;
    done_d     = '0;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data_q;
    grant_id_d = grant_id_q;
    unique case (state_q)
      StIdle: begin
        if (arb_valid) begin
          tx_data_d  = bus.data_in[32'(arb_idx) * BIT_LEN +: BIT_LEN];
          grant_id_d = arb_idx;
          ack_d      = arb_gnt;
          tx_start_d = 1'b1;
          rr_ptr_d   = IdxW'((32'(arb_idx) + 32'd1) % N_REQ);
          state_d    = StStart;
        end
      end
      StStart: begin
        cnt_d   = '0;
        state_d = StWait;
      end
      StWait: begin
        if (cnt_q == FrameLast) begin
          done_d[grant_id_q] = 1'b1;
          cnt_d              = '0;
          state_d            = (GAP_CYCLES == 0) ? StIdle : StGap;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StGap: begin
        if (cnt_q == GapLast) begin
          cnt_d   = '0;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
    // busy is registered, so it follows the state being entered.
    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      rr_ptr_q   <= '0;
      ack_q      <= '0;
      done_q     <= '0;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
      busy_q     <= 1'b0;
      grant_id_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rr_ptr_q   <= rr_ptr_d;
      ack_q      <= ack_d;
      done_q     <= done_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
      busy_q     <= busy_d;
      grant_id_q <= grant_id_d;
    end
  end

  assign bus.ack      = ack_q;
  assign bus.done     = done_q;
  assign bus.tx_start = tx_start_q;
  assign bus.tx_data  = tx_data_q;
  assign bus.busy     = busy_q;
  assign bus.grant_id = grant_id_q;

endmodule

// File: tb/tb_tx_scheduler.sv
// Scoreboard bench for tx_scheduler: a transaction-level model predicts grants
// and frame timing from sampled requests; a monitor checks what the DUT emits.
module tb_tx_scheduler;
  import tx_pkg::*;

  localparam int N  = 4;
  localparam int BL = 7;
  localparam int F  = 11;
  localparam int G  = 1;
  localparam int F2 = 3;

  logic clk  = 1'b0;
  logic rstn = 1'b1;
  always #5 clk = ~clk;

  tx_scheduler_if #(.N_REQ(N), .BIT_LEN(BL)) bus ();
  tx_scheduler_if #(.N_REQ(N), .BIT_LEN(BL)) bus2 ();

  tx_scheduler #(.N_REQ(N), .BIT_LEN(BL), .FRAME_CYCLES(F), .GAP_CYCLES(G)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus.slave)
  );

  tx_scheduler #(.N_REQ(N), .BIT_LEN(BL), .FRAME_CYCLES(F2), .GAP_CYCLES(0)) dut2 (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus2.slave)
  );

  typedef struct {
    int          w;
    logic [BL-1:0] data;
    int          start_cyc;
  } exp_t;

  exp_t exp_q[$];
  int   cyc   = 0;
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_vec++;
    n_bad++;
    $display("FAIL %s: event not as required (cycle %0d)", name, cyc);
  endtask

  // Reference model: arbitration opportunities are one period apart after a grant.
  initial begin : model
    int ptr;
    int next_arb;
    int w;
    ptr      = 0;
    next_arb = 1;
    forever begin
      @(posedge clk);
      cyc++;
      if (!rstn) begin
        ptr      = 0;
        next_arb = cyc + 1;
        exp_q.delete();
      end else if (cyc == next_arb) begin
        w = -1;
        for (int k = 0; k < N; k++)
          if (w < 0 && bus.req[(ptr + k) % N]) w = (ptr + k) % N;
        if (w >= 0) begin
          exp_q.push_back('{w, bus.data_in[w*BL +: BL], cyc});
          ptr      = (w + 1) % N;
          next_arb = cyc + F + G + 2;
        end else begin
          next_arb = cyc + 1;
        end
      end
    end
  end

  initial begin : monitor
    bit   active;
    exp_t cur;
    int   done_cyc;
    active = 0;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        active = 0;
        continue;
      end
      if (exp_q.size() > 0 && cyc > exp_q[0].start_cyc) begin
        fail_now("missing_tx_start");
        void'(exp_q.pop_front());
      end
      if (bus.tx_start) begin
        if (exp_q.size() == 0) begin
          fail_now("unexpected_tx_start");
        end else begin
          cur = exp_q.pop_front();
          check("start_cycle", cyc, cur.start_cyc);
          check("grant_id", 32'(bus.grant_id), cur.w);
          check("ack", 32'(bus.ack), 32'(1) << cur.w);
          check("tx_data", 32'(bus.tx_data), 32'(cur.data));
          check("busy", 32'(bus.busy), 1);
          active   = 1;
          done_cyc = cur.start_cyc + F + 1;
        end
      end else begin
        if (bus.ack != '0) fail_now("unexpected_ack");
        if (active) check("tx_data_hold", 32'(bus.tx_data), 32'(cur.data));
      end
      if (bus.done != '0) begin
        if (!active) begin
          fail_now("unexpected_done");
        end else begin
          check("done_cycle", cyc, done_cyc);
          check("done_vec", 32'(bus.done), 32'(1) << cur.w);
          active = 0;
        end
      end else if (active && cyc > done_cyc) begin
        fail_now("missing_done");
        active = 0;
      end
    end
  end

  task automatic check_reset_outputs();
    check("rst_ack", 32'(bus.ack), 0);
    check("rst_done", 32'(bus.done), 0);
    check("rst_tx_start", 32'(bus.tx_start), 0);
    check("rst_tx_data", 32'(bus.tx_data), 0);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_grant_id", 32'(bus.grant_id), 0);
  endtask

  // Assert reset between edges so the outputs must clear asynchronously.
  task automatic assert_reset();
    @(posedge clk);
    #2 rstn = 1'b0;
    #1 check_reset_outputs();
  endtask

  task automatic wait_start(input int budget, output bit ok);
    ok = 0;
    for (int t = 0; t < budget; t++) begin
      @(negedge clk);
      if (bus.tx_start) begin
        ok = 1;
        break;
      end
    end
    if (!ok) fail_now("tx_start_timeout");
  endtask

  task automatic rand_cycle();
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      if (bus.ack[i]) begin
        if ($urandom_range(1, 0) == 1) bus.data_in[i*BL +: BL] = BL'($urandom);
        else bus.req[i] = 1'b0;
      end else if (bus.req[i]) begin
        if ($urandom_range(99, 0) < 2) bus.req[i] = 1'b0;
      end else if ($urandom_range(99, 0) < 10) begin
        bus.data_in[i*BL +: BL] = BL'($urandom);
        bus.req[i] = 1'b1;
      end
    end
  endtask

  initial begin : stim
    bit ok;
    int last;
    logic [BL-1:0] held;
    bus.req      = '0;
    bus.data_in  = '0;
    bus2.req     = '0;
    bus2.data_in = '0;
    #1 rstn = 1'b0;
    #1 check_reset_outputs();
    repeat (2) @(negedge clk);
    rstn = 1'b1;

    // Single requester 2 with a known word.
    bus.data_in[2*BL +: BL] = 7'h5A;
    bus.req = 4'b0100;
    wait_start(5, ok);
    check("ack2_first", 32'(bus.ack), 32'h4);
    bus.req = '0;
    repeat (20) @(negedge clk);

    // All four requesting from a fresh pointer.
    assert_reset();
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    for (int i = 0; i < N; i++) bus.data_in[i*BL +: BL] = BL'($urandom);
    bus.req = 4'b1111;
    last = 0;
    for (int g = 0; g < 5; g++) begin
      wait_start(30, ok);
      check("rr_order", 32'(bus.grant_id), g % N);
      if (g > 0) check("rr_spacing", cyc - last, F + G + 2);
      last = cyc;
    end

    // Late request for 1 and a withdrawn pulse on 0 during a frame for 3.
    bus.req = 4'b1000;
    wait_start(30, ok);
    check("grant3", 32'(bus.grant_id), 3);
    last = cyc;
    held = bus.tx_data;
    bus.req = '0;
    repeat (4) @(negedge clk);
    bus.req[0] = 1'b1;
    @(negedge clk);
    bus.req[0] = 1'b0;
    bus.data_in[1*BL +: BL] = BL'($urandom);
    bus.req[1] = 1'b1;
    repeat (3) @(negedge clk);
    check("mid_frame_data", 32'(bus.tx_data), 32'(held));
    wait_start(30, ok);
    check("late_grant1", 32'(bus.grant_id), 1);
    check("late_spacing", cyc - last, F + G + 2);
    bus.req = '0;

    // Abort in the middle of a frame; pointer restarts at 0.
    repeat (6) @(negedge clk);
    assert_reset();
    bus.req = 4'b1000;
    repeat (5) @(negedge clk);
    rstn = 1'b1;
    wait_start(10, ok);
    check("post_rst_grant", 32'(bus.grant_id), 3);
    bus.req = '0;
    repeat (20) @(negedge clk);

    for (int c = 0; c < 600; c++) rand_cycle();
    @(negedge clk);
    bus.req = '0;
    repeat (30) @(negedge clk);
    check("drain", exp_q.size(), 0);

    // No gap, short frame: two requesters alternate every five cycles.
    bus2.data_in = 28'h1234567;
    bus2.req     = 4'b0011;
    last = 0;
    for (int g = 0; g < 6; g++) begin
      ok = 0;
      for (int t = 0; t < 12; t++) begin
        @(negedge clk);
        if (bus2.tx_start) begin
          ok = 1;
          break;
        end
      end
      if (!ok) fail_now("g0_timeout");
      check("g0_grant", 32'(bus2.grant_id), g % 2);
      if (g > 0) check("g0_spacing", cyc - last, F2 + 2);
      last = cyc;
    end
    bus2.req = '0;
    repeat (10) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
